// File: rtl/mat_pkg.sv
// Shared constants and types for the systolic-array datapath: element width,
// array dimension defaults and the A-loader state encoding.
package mat_pkg;

  localparam int BITS_AB_DEF = 8;
  localparam int DIM_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/mat_a_loader.sv
// Streams a DIM x DIM A-matrix in row-major order, assembles each row into a
// vector and issues one single-cycle row write per row to the A buffer.
//
// state | meaning
// IDLE  | waiting for start; no elements consumed
// LOAD  | accepting elements into the row buffer
// WRITE | one-cycle row write of the assembled vector
// DONE  | one-cycle completion pulse after the last row
module mat_a_loader
  import mat_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int DIM     = DIM_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              in_valid,
  input  logic signed [BITS_AB-1:0]         in_data,
  output logic                              in_ready,
  output logic                              WrEn,
  output logic [$clog2(DIM)-1:0]            Arow,
  output logic [DIM-1:0][BITS_AB-1:0]       Ain,
  output logic                              busy,
  output logic                              done
);

  localparam int AW = $clog2(DIM);
  localparam logic [AW-1:0] LAST_IDX = AW'(DIM - 1);

  loader_state_t                state_q, state_d;
  logic [AW-1:0]                col_q, col_d;
  logic [AW-1:0]                row_q, row_d;
  logic [DIM-1:0][BITS_AB-1:0]  row_buf_q, row_buf_d;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    row_buf_d = row_buf_q;
    if (abort) begin
      // abort also covers IDLE, so start+abort there stays idle
      state_d = IDLE;
      col_d   = '0;
      row_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD;
            col_d   = '0;
            row_d   = '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            row_buf_d[col_q] = in_data;
            col_d            = col_q + 1'b1;
            if (col_q == LAST_IDX) begin
              state_d = WRITE;
            end
          end
        end
        WRITE: begin
          if (row_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + 1'b1;
            col_d   = '0;
            state_d = LOAD;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      row_buf_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      row_buf_q <= row_buf_d;
    end
  end

  // abort gating is the only input-to-output path: it must kill a coincident write/done
  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign WrEn     = (state_q == WRITE) && !abort;
  assign done     = (state_q == DONE) && !abort;
  assign Arow     = row_q;
  assign Ain      = row_buf_q;

endmodule

// File: tb/tb_mat_a_loader.sv
// Directed bench for mat_a_loader (DIM=8, BITS_AB=8) with hand-derived cycle schedules.
module tb_mat_a_loader;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic              in_valid;
  logic signed [7:0] in_data;
  logic              in_ready;
  logic              WrEn;
  logic [2:0]        Arow;
  logic [7:0][7:0]   Ain;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;

  mat_a_loader #(.BITS_AB(8), .DIM(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .WrEn(WrEn), .Arow(Arow), .Ain(Ain), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_idle_then_start(input string name);
    @(posedge clk); #1;
    start = 1'b1;
    #1;
    checks++;
    if ({in_ready, WrEn, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_idle got=%b exp=0000", name, {in_ready, WrEn, busy, done});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({in_ready, WrEn, Arow, busy, done} !== 7'b0 || Ain !== 64'b0) begin
      errors++;
      $display("FAIL reset_in got=%b ain=%h exp=0", {in_ready, WrEn, Arow, busy, done}, Ain);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #2;
    checks++;
    if ({in_ready, WrEn, Arow, busy, done} !== 7'b0 || Ain !== 64'b0) begin
      errors++;
      $display("FAIL reset_out got=%b ain=%h exp=0", {in_ready, WrEn, Arow, busy, done}, Ain);
    end
  endtask

  // in_valid held high, data 0..63: writes at 9(r+1), done at 73
  task automatic test_basic();
    int e = 0;
    int r;
    logic er, ew, ed;
    in_valid = 1'b1; in_data = 8'sd0;
    check_idle_then_start("basic");
    for (int k = 1; k <= 73; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      er = (k <= 72) && (k % 9 != 0);
      ew = (k <= 72) && (k % 9 == 0);
      ed = (k == 73);
      if (er) begin in_data = 8'(e); e++; end
      #1;
      checks++;
      if ({in_ready, WrEn, busy, done} !== {er, ew, 1'b1, ed}) begin
        errors++;
        $display("FAIL basic_ctl k=%0d got=%b exp=%b", k, {in_ready, WrEn, busy, done}, {er, ew, 1'b1, ed});
      end
      if (ew) begin
        r = k / 9 - 1;
        checks++;
        if (Arow !== 3'(r)) begin
          errors++;
          $display("FAIL basic_arow k=%0d got=%0d exp=%0d", k, Arow, r);
        end
        for (int j = 0; j < 8; j++) begin
          checks++;
          if (Ain[j] !== 8'(8 * r + j)) begin
            errors++;
            $display("FAIL basic_ain r=%0d j=%0d got=%h exp=%h", r, j, Ain[j], 8'(8 * r + j));
          end
        end
      end
    end
  endtask

  // starts in the first idle cycle after the previous done (back-to-back)
  task automatic test_signed();
    int r;
    logic ew;
    in_valid = 1'b1; in_data = -8'sd128;
    check_idle_then_start("signed");
    for (int k = 1; k <= 73; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ew = (k <= 72) && (k % 9 == 0);
      #1;
      checks++;
      if ({WrEn, busy, done} !== {ew, 1'b1, k == 73}) begin
        errors++;
        $display("FAIL signed_ctl k=%0d got=%b exp=%b", k, {WrEn, busy, done}, {ew, 1'b1, k == 73});
      end
      if (ew) begin
        r = k / 9 - 1;
        checks++;
        if (Arow !== 3'(r)) begin
          errors++;
          $display("FAIL signed_arow k=%0d got=%0d exp=%0d", k, Arow, r);
        end
        for (int j = 0; j < 8; j++) begin
          checks++;
          if ($signed(Ain[j]) !== -8'sd128) begin
            errors++;
            $display("FAIL signed_ain r=%0d j=%0d got=%0d exp=-128", r, j, $signed(Ain[j]));
          end
        end
      end
    end
  endtask

  // in_valid high on even cycles only: row r written at 16r+17, done at 130
  task automatic test_bursty();
    int e = 0;
    int r;
    logic er, ew, ed;
    in_valid = 1'b1; in_data = 8'hEE;
    check_idle_then_start("bursty");
    for (int k = 1; k <= 130; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = (k % 2 == 0);
      ew = (k >= 17) && (k <= 129) && ((k - 1) % 16 == 0);
      er = (k <= 129) && !ew;
      ed = (k == 130);
      if (er && in_valid) begin in_data = 8'(e * 3 + 5); e++; end
      #1;
      checks++;
      if ({in_ready, WrEn, busy, done} !== {er, ew, 1'b1, ed}) begin
        errors++;
        $display("FAIL bursty_ctl k=%0d got=%b exp=%b", k, {in_ready, WrEn, busy, done}, {er, ew, 1'b1, ed});
      end
      if (ew) begin
        r = (k - 17) / 16;
        checks++;
        if (Arow !== 3'(r)) begin
          errors++;
          $display("FAIL bursty_arow k=%0d got=%0d exp=%0d", k, Arow, r);
        end
        for (int j = 0; j < 8; j++) begin
          checks++;
          if (Ain[j] !== 8'((8 * r + j) * 3 + 5)) begin
            errors++;
            $display("FAIL bursty_ain r=%0d j=%0d got=%h exp=%h", r, j, Ain[j], 8'((8 * r + j) * 3 + 5));
          end
        end
      end
    end
    in_valid = 1'b1;
  endtask

  // abort on the 20th accept (cycle 22), then a fresh matrix aborted during its second WRITE
  task automatic test_abort();
    int e = 0;
    int wcount = 0;
    logic er, ew, eb;
    in_valid = 1'b1; in_data = 8'sd0;
    check_idle_then_start("abort1");
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = (k == 22);
      er = (k <= 22) && (k % 9 != 0);
      ew = (k == 9) || (k == 18);
      eb = (k <= 22);
      if (er) begin in_data = 8'(e); e++; end
      #1;
      if (WrEn) wcount++;
      checks++;
      if ({in_ready, WrEn, busy, done} !== {er, ew, eb, 1'b0}) begin
        errors++;
        $display("FAIL abort1_ctl k=%0d got=%b exp=%b", k, {in_ready, WrEn, busy, done}, {er, ew, eb, 1'b0});
      end
      if (ew) begin
        checks++;
        if (Arow !== 3'(k / 9 - 1) || Ain[3] !== 8'(8 * (k / 9 - 1) + 3)) begin
          errors++;
          $display("FAIL abort1_row k=%0d got=%0d/%h exp=%0d/%h", k, Arow, Ain[3], k / 9 - 1, 8'(8 * (k / 9 - 1) + 3));
        end
      end
    end
    abort = 1'b0;
    checks++;
    if (wcount !== 2) begin
      errors++;
      $display("FAIL abort1_wrcount got=%0d exp=2", wcount);
    end
    e = 0;
    check_idle_then_start("abort2");
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = (k == 18);
      er = (k <= 17) && (k != 9);
      ew = (k == 9);
      eb = (k <= 18);
      if (er) begin in_data = 8'(100 + e); e++; end
      #1;
      checks++;
      if ({in_ready, WrEn, busy, done} !== {er, ew, eb, 1'b0}) begin
        errors++;
        $display("FAIL abort2_ctl k=%0d got=%b exp=%b", k, {in_ready, WrEn, busy, done}, {er, ew, eb, 1'b0});
      end
      if (ew) begin
        checks++;
        if (Arow !== 3'd0) begin
          errors++;
          $display("FAIL abort2_arow got=%0d exp=0", Arow);
        end
        for (int j = 0; j < 8; j++) begin
          checks++;
          if (Ain[j] !== 8'(100 + j)) begin
            errors++;
            $display("FAIL abort2_ain j=%0d got=%h exp=%h", j, Ain[j], 8'(100 + j));
          end
        end
      end
    end
    abort = 1'b0;
  endtask

  // start re-asserted at cycle 5 (ignored), rst_n low during cycles 40..41
  task automatic test_midload_reset();
    int e = 0;
    logic er, ew;
    in_valid = 1'b1; in_data = 8'sd0;
    check_idle_then_start("rst");
    for (int k = 1; k <= 39; k++) begin
      @(posedge clk); #1;
      start = (k == 5);
      er = (k % 9 != 0);
      ew = (k % 9 == 0);
      if (er) begin in_data = 8'(e); e++; end
      #1;
      checks++;
      if ({in_ready, WrEn, busy, done} !== {er, ew, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL rst_ctl k=%0d got=%b exp=%b", k, {in_ready, WrEn, busy, done}, {er, ew, 1'b1, 1'b0});
      end
      if (ew) begin
        checks++;
        if (Arow !== 3'(k / 9 - 1) || Ain[0] !== 8'(8 * (k / 9 - 1)) || Ain[7] !== 8'(8 * (k / 9 - 1) + 7)) begin
          errors++;
          $display("FAIL rst_row k=%0d got=%0d/%h/%h", k, Arow, Ain[0], Ain[7]);
        end
      end
    end
    start = 1'b0;
    for (int k = 40; k <= 41; k++) begin
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, WrEn, Arow, busy, done} !== 7'b0 || Ain !== 64'b0) begin
        errors++;
        $display("FAIL rst_async k=%0d got=%b ain=%h exp=0", k, {in_ready, WrEn, Arow, busy, done}, Ain);
      end
    end
    for (int k = 42; k <= 61; k++) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
      in_data = 8'(k);
      #1;
      checks++;
      if ({in_ready, WrEn, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL rst_quiet k=%0d got=%b exp=0000", k, {in_ready, WrEn, busy, done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_bursty();
    test_abort();
    test_midload_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
